// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared SAP-1 constants and loader state encodings
//
// Purpose: width constants used across the SAP-1 slice plus the ram_loader
//          FSM state type and a small state-decoding helper.
// Ports:   none (package).
package sap1_pkg;

  localparam int SAP1_WIDTH      = 8;
  localparam int SAP1_RAM_DEPTH  = 16;
  localparam int SAP1_ADDR_WIDTH = $clog2(SAP1_RAM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } loader_state_t;

  // A session is in progress from the first LOAD cycle until DONE.
  function automatic logic loader_is_busy(input loader_state_t s);
    return (s == ST_LOAD) || (s == ST_CHECK) || (s == ST_VERIFY);
  endfunction

endpackage

// File: rtl/ram_loader_if.sv
// rtl/ram_loader_if.sv - stream, RAM and status signals of ram_loader
//
// Purpose: bundles the upstream word stream, the RAM write/read port and the
//          session status of ram_loader.
// Modports:
//   slave  - the loader: takes i_start/i_valid/i_data/i_ram_data, drives
//            o_ready, o_address, o_load_enable, o_load_data, o_busy,
//            o_done, o_error.
//   master - the environment side (upstream source, RAM, controller).
interface ram_loader_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
);

  logic                  i_start;
  logic                  i_valid;
  logic [WIDTH-1:0]      i_data;
  logic                  o_ready;
  logic [ADDR_WIDTH-1:0] o_address;
  logic                  o_load_enable;
  logic [WIDTH-1:0]      o_load_data;
  logic [WIDTH-1:0]      i_ram_data;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_error;

  modport slave (
    input  i_start, i_valid, i_data, i_ram_data,
    output o_ready, o_address, o_load_enable, o_load_data,
           o_busy, o_done, o_error
  );

  modport master (
    output i_start, i_valid, i_data, i_ram_data,
    input  o_ready, o_address, o_load_enable, o_load_data,
           o_busy, o_done, o_error
  );

endinterface

// File: rtl/ram.sv
// rtl/ram.sv - SAP-1 RAM: clocked write, combinational read
//
// Purpose: DEPTH x WIDTH storage. A write happens on the rising clk edge when
//          both clk_en and i_load_enable are high; o_data is the word at
//          i_address, combinationally.
// Ports:
//   clk, clk_en              - clock and global step enable
//   i_address                - read/write address
//   i_load_enable            - write request
//   i_load_data              - write data
//   o_data                   - read data
import sap1_pkg::*;

module Ram #(
  parameter int DEPTH = SAP1_RAM_DEPTH,
  parameter int WIDTH = SAP1_WIDTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  clk_en,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic                  i_load_enable,
  input  logic [WIDTH-1:0]      i_load_data,
  output logic [WIDTH-1:0]      o_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clk_en && i_load_enable) begin
      mem[i_address] <= i_load_data;
    end
  end

  assign o_data = mem[i_address];

endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - streams an image into RAM, then verifies its checksum
//
// Purpose: a session (i_start) writes RAM_DEPTH upstream words to RAM at
//          addresses 0..RAM_DEPTH-1, takes one more word as the expected
//          checksum, reads the RAM back summing modulo 2^WIDTH and reports
//          o_error when the sum differs from the checksum.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   clk_en  - global step enable; no state changes while low
//   bus     - ram_loader_if.slave: i_start, i_valid/i_data/o_ready stream,
//             o_address/o_load_enable/o_load_data/i_ram_data RAM port,
//             o_busy/o_done/o_error status
import sap1_pkg::*;

module ram_loader #(
  parameter int RAM_DEPTH = SAP1_RAM_DEPTH,
  parameter int WIDTH     = SAP1_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  ram_loader_if.slave  bus
);

  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  loader_state_t         state, state_d;
  logic [ADDR_WIDTH-1:0] cnt, cnt_d;
  logic [WIDTH-1:0]      sum, sum_d;
  logic [WIDTH-1:0]      expected, expected_d;
  logic                  err, err_d;

  logic                  ready;
  logic                  xfer;
  logic                  last;
  logic [ADDR_WIDTH-1:0] cnt_inc;

  assign ready   = (state == ST_LOAD) || (state == ST_CHECK);
  // clk_en qualification is applied at the register update.
  assign xfer    = bus.i_valid && ready;
  assign last    = (cnt == LAST_ADDR);
  // Explicit wrap keeps the counter correct for non-power-of-two depths.
  assign cnt_inc = last ? '0 : cnt + ADDR_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      sum      <= '0;
      expected <= '0;
      err      <= 1'b0;
    end else if (clk_en) begin
      cnt      <= cnt_d;
      sum      <= sum_d;
      expected <= expected_d;
      err      <= err_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    sum_d      = sum;
    expected_d = expected;
    err_d      = err;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.i_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          sum_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          sum_d = sum + bus.i_data;
          cnt_d = cnt_inc;
          if (last) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          expected_d = bus.i_data;
          sum_d      = '0;
          state_d    = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        // One RAM word per enabled cycle; the read is combinational at cnt.
        sum_d = sum + bus.i_ram_data;
        cnt_d = cnt_inc;
        if (last) begin
          state_d = ST_DONE;
          err_d   = (sum_d != expected);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write request is not gated by clk_en: the RAM qualifies it itself, so the
  // write lands on the very edge that accepts the word.
  assign bus.o_ready       = ready;
  assign bus.o_address     = cnt;
  assign bus.o_load_enable = (state == ST_LOAD) && bus.i_valid;
  assign bus.o_load_data   = (state == ST_LOAD) ? bus.i_data : '0;
  assign bus.o_busy        = loader_is_busy(state);
  assign bus.o_done        = (state == ST_DONE);
  assign bus.o_error       = err;

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - scoreboard testbench for ram_loader paired with Ram
module tb_ram_loader;
  import sap1_pkg::*;

  localparam int DEPTH = 16;
  localparam int W     = 8;
  localparam int AW    = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_en = 1'b1;
  logic [W-1:0] ram_q;

  ram_loader_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  ram_loader #(.RAM_DEPTH(DEPTH), .WIDTH(W)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus.slave)
  );

  Ram #(.DEPTH(DEPTH), .WIDTH(W)) u_ram (
    .clk           (clk),
    .clk_en        (clk_en),
    .i_address     (bus.o_address),
    .i_load_enable (bus.o_load_enable),
    .i_load_data   (bus.o_load_data),
    .o_data        (ram_q)
  );

  assign bus.i_ram_data = ram_q;

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [AW+W-1:0] exp_wr[$];   // {address, data} of each expected RAM write
  bit              exp_res[$];  // expected o_error of each completed session
  logic [AW-1:0]   addr_model;
  bit              throttle = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // clk_en alternates every cycle while throttling, else stays high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      clk_en = throttle ? ~clk_en : 1'b1;
    end
  end

  // Monitor: checks RAM writes, held-off writes, VERIFY length and results.
  initial begin
    int  vcount = 0;
    bit  done_prev = 1'b0;
    bit  hold_pending = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    logic [W-1:0]  hold_val = '0;
    logic [AW+W-1:0] e;
    forever begin
      @(negedge clk);
      if (hold_pending) begin
        check("no_write_clk_en_low", int'(u_ram.mem[hold_addr]), int'(hold_val));
        hold_pending = 1'b0;
      end
      if (rst_n && !clk_en && bus.o_load_enable) begin
        hold_addr    = bus.o_address;
        hold_val     = u_ram.mem[bus.o_address];
        hold_pending = 1'b1;
      end
      if (rst_n && clk_en && bus.o_load_enable) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_wr.pop_front();
          check("write_addr", int'(bus.o_address), int'(e[AW+W-1:W]));
          check("write_data", int'(bus.o_load_data), int'(e[W-1:0]));
        end
      end
      if (bus.o_busy && bus.o_ready) vcount = 0;
      if (clk_en && bus.o_busy && !bus.o_ready) vcount++;
      if (bus.o_done && !done_prev) begin
        if (exp_res.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("o_error", int'(bus.o_error), int'(exp_res.pop_front()));
          check("verify_cycles", vcount, DEPTH);
        end
      end
      done_prev = bus.o_done;
    end
  end

  task automatic step_enabled();
    @(negedge clk);
    while (!clk_en) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    step_enabled();
    bus.i_start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input bit is_load);
    bit fired = 1'b0;
    int cycles = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    if (is_load) begin
      exp_wr.push_back({addr_model, d});
      addr_model = addr_model + 1'b1;
    end
    while (!fired && cycles < 100) begin
      @(negedge clk);
      fired = clk_en && bus.o_ready;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!fired) check("send_timeout", 0, 1);
    bus.i_valid = 1'b0;
    if (throttle) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done();
    int cycles = 0;
    @(negedge clk);
    while (!bus.o_done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (!bus.o_done) check("done_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_session(input logic [W-1:0] base, input bit inc,
                             input logic [W-1:0] cs, input bit err,
                             input bit poke_start);
    addr_model = '0;
    pulse_start();
    exp_res.push_back(err);
    for (int i = 0; i < DEPTH; i++) begin
      if (poke_start && i == 3) begin
        bus.i_valid = 1'b0;
        pulse_start();
        check("busy_after_start_poke", int'(bus.o_busy), 1);
      end
      send(inc ? base + W'(i) : base, 1'b1);
    end
    send(cs, 1'b0);
    wait_done();
  endtask

  task automatic check_ram(input logic [W-1:0] base, input bit inc);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("ram[%0d]", i), int'(u_ram.mem[i]),
            int'(inc ? base + W'(i) : base));
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    #1;
    check("rst_busy",    int'(bus.o_busy), 0);
    check("rst_done",    int'(bus.o_done), 0);
    check("rst_error",   int'(bus.o_error), 0);
    check("rst_ready",   int'(bus.o_ready), 0);
    check("rst_load_en", int'(bus.o_load_enable), 0);
    check("rst_address", int'(bus.o_address), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0x00..0x0F sums to 0x78.
    run_session(8'h00, 1'b1, 8'h78, 1'b0, 1'b0);
    check("done_a", int'(bus.o_done), 1);
    check_ram(8'h00, 1'b1);

    run_session(8'h00, 1'b1, 8'h77, 1'b1, 1'b0);
    check("done_b", int'(bus.o_done), 1);
    check("error_held_b", int'(bus.o_error), 1);

    // 0x10..0x1F sums to 0x178 -> 0x78; i_start poked mid-LOAD.
    run_session(8'h10, 1'b1, 8'h78, 1'b0, 1'b1);
    check_ram(8'h10, 1'b1);

    // Throttled stream and clk_en: 0x20..0x2F sums to 0x278 -> 0x78.
    throttle = 1'b1;
    run_session(8'h20, 1'b1, 8'h78, 1'b0, 1'b0);
    throttle = 1'b0;
    @(posedge clk);
    #1;
    check_ram(8'h20, 1'b1);

    // 16 x 0xFF = 0xFF0 -> 0xF0 after wrap.
    run_session(8'hFF, 1'b0, 8'hF0, 1'b0, 1'b0);
    check_ram(8'hFF, 1'b0);

    // Reset after five words: session aborts immediately.
    addr_model = '0;
    pulse_start();
    for (int i = 0; i < 5; i++) send(8'hA0 + W'(i), 1'b1);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h55;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy",    int'(bus.o_busy), 0);
    check("abort_ready",   int'(bus.o_ready), 0);
    check("abort_load_en", int'(bus.o_load_enable), 0);
    check("abort_done",    int'(bus.o_done), 0);
    check("abort_address", int'(bus.o_address), 0);
    check("abort_pending_writes", exp_wr.size(), 0);
    bus.i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("abort_ram[%0d]", i), int'(u_ram.mem[i]),
            (i < 5) ? 8'hA0 + i : 8'hFF);

    run_session(8'h00, 1'b1, 8'h78, 1'b0, 1'b0);
    check("done_fresh", int'(bus.o_done), 1);
    check_ram(8'h00, 1'b1);

    check("writes_drained",  exp_wr.size(), 0);
    check("results_drained", exp_res.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as listed in REQ-002 to REQ-004.
REQ-002 RAM_DEPTH, 16, number of RAM words loaded per image.
REQ-003 WIDTH, 8, data word width.
REQ-004 ADDR_WIDTH, $clog2(RAM_DEPTH), local, not overridable.
REQ-005 Ports (name, direction, width, meaning) SHALL be as listed in REQ-006 to REQ-019; there SHALL be one clock, and reset SHALL be asynchronous, active-low.
REQ-006 clk, in, 1, sole clock, rising edge.
REQ-007 rst_n, in, 1, asynchronous active-low reset.
REQ-008 clk_en, in, 1, global step enable; no state changes while low.
REQ-009 i_start, in, 1, begin a load session (sampled in IDLE/DONE only).
REQ-010 i_valid, in, 1, upstream byte-stream word valid.
REQ-011 i_data, in, WIDTH, upstream word.
REQ-012 o_ready, out, 1, loader can accept i_data this cycle.
REQ-013 o_address, out, ADDR_WIDTH, RAM address.
REQ-014 o_load_enable, out, 1, RAM write request (RAM gates it with clk_en).
REQ-015 o_load_data, out, WIDTH, RAM write data.
REQ-016 i_ram_data, in, WIDTH, RAM combinational read data at o_address.
REQ-017 o_busy, out, 1, session in progress (state LOAD, CHECK or VERIFY).
REQ-018 o_done, out, 1, session complete (state DONE).
REQ-019 o_error, out, 1, checksum mismatch; valid while o_done=1.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, CHECK, VERIFY and DONE; all registered state advances SHALL occur only on rising clk edges with clk_en=1.
REQ-021 IDLE or DONE with i_start=1 SHALL go to LOAD, and SHALL clear the address counter, the running sum and o_error.
REQ-022 A transfer SHALL occur when i_valid & o_ready & clk_en; o_ready SHALL be 1 in LOAD and CHECK, else 0.
REQ-023 In LOAD, o_load_enable SHALL equal i_valid, o_load_data SHALL equal i_data, and o_address SHALL equal the counter, all combinationally; the RAM write SHALL occur on the same edge as the transfer (zero latency).
REQ-024 Outside LOAD, o_load_enable SHALL be 0 and o_load_data SHALL be 0.
REQ-025 Each LOAD transfer SHALL add i_data to the running sum, modulo 2^WIDTH, and SHALL increment the counter.
REQ-026 When the transfer at counter=RAM_DEPTH-1 completes, the counter SHALL wrap to 0 and the FSM SHALL go to CHECK.
REQ-027 In CHECK, one transfer SHALL latch i_data as the expected checksum, SHALL clear the running sum and SHALL go to VERIFY.
REQ-028 In VERIFY, each clk_en cycle SHALL add i_ram_data (at o_address=counter) to the running sum and SHALL increment the counter, taking exactly RAM_DEPTH clk_en cycles.
REQ-029 After the VERIFY cycle at counter=RAM_DEPTH-1, the FSM SHALL go to DONE with o_error = (final sum != expected checksum).
REQ-030 DONE SHALL hold o_done=1 and o_error until the next i_start.
REQ-031 While o_busy=1, i_start SHALL be ignored.
REQ-032 With clk_en=0, outputs SHALL be held steady and o_load_enable SHALL still follow REQ-023, because the RAM suppresses the write.
REQ-033 i_valid=0 stall cycles in LOAD or CHECK SHALL leave the counter and the sum unchanged.
REQ-034 In IDLE, CHECK and DONE, o_address SHALL equal the counter, which is 0.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, counter=0, sum=0, expected=0, o_ready=0, o_load_enable=0, o_busy=0, o_done=0 and o_error=0.
REQ-036 A reset asserted mid-session SHALL abort the session; already-written RAM words SHALL remain as written, and no partial write SHALL be issued after reset.
REQ-037 Release of rst_n SHALL take effect at the next rising clk edge.

Structure
REQ-038 The state encodings SHALL be defined in the shared package sap1_pkg, alongside the existing SAP-1 width constants.
REQ-039 The block SHALL have no sub-module; the counter, the sum and the FSM SHALL be inline.
REQ-040 The testbench SHALL pair ram_loader with the existing Ram by connecting o_address, o_load_enable and o_load_data to Ram, and Ram o_data to i_ram_data.

Verification
REQ-041 Reset release, i_start, 16 words 0x00..0x0F, then checksum 0x78 -> Ram holds 0x00..0x0F, o_done=1, o_error=0, 16 VERIFY cycles observed.
REQ-042 Same image with checksum 0x77 -> o_done=1, o_error=1.
REQ-043 i_valid toggled 1/0 and clk_en toggled 1/0 throughout -> identical final Ram contents, no write while clk_en=0, and counter unchanged on stall cycles.
REQ-044 Words 0xFF x16 with checksum 0xF0 (sum wrap) -> o_error=0.
REQ-045 rst_n pulsed low after 5 words -> immediate IDLE; addresses 0..4 written, 5..15 untouched, and a fresh session completes correctly.
REQ-046 i_start pulsed during LOAD -> ignored, counter unaffected.
